// File: rtl/tokenizer_pkg.sv
// Shared types for the tokenizer blocks.
// Holds the decoder FSM encoding and default code constants.
package tokenizer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_CODE,
        EV_CODE,
        RD_VOC,
        EV_VOC,
        DONE,
        ERR
    } decoder_state;

    localparam int DEF_DATA_WIDTH = 8;
    localparam logic [DEF_DATA_WIDTH-1:0] DEF_END_CODE = '1;

endpackage

// File: rtl/token_decoder.sv
// Token decoder: expands code SRAM entries into vocab strings,
// writing zero-terminated text to the output SRAM.
module token_decoder
    import tokenizer_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] END_CODE = {DATA_WIDTH{1'b1}}
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cs,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_WIDTH-1:0] code_addr,
    input  logic [DATA_WIDTH-1:0] code_rdata,
    output logic [ADDR_WIDTH-1:0] vocab_addr,
    input  logic [DATA_WIDTH-1:0] vocab_rdata,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic [DATA_WIDTH-1:0] out_wdata,
    output logic                  out_we
);

    decoder_state state, state_d;

    logic [DATA_WIDTH-1:0] target, target_d;
    logic [DATA_WIDTH-1:0] tok_cnt, tok_cnt_d;
    logic                  prev_zero, prev_zero_d;
    logic                  done_d, err_d;
    logic [ADDR_WIDTH-1:0] code_addr_d, vocab_addr_d, out_addr_d;

    logic b_zero, hit;

    assign b_zero = (vocab_rdata == '0);
    assign hit    = (tok_cnt == target);
    assign busy   = !(state == IDLE || state == DONE || state == ERR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            target     <= '0;
            tok_cnt    <= '0;
            prev_zero  <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            code_addr  <= '0;
            vocab_addr <= '0;
            out_addr   <= '0;
        end else begin
            state      <= state_d;
            target     <= target_d;
            tok_cnt    <= tok_cnt_d;
            prev_zero  <= prev_zero_d;
            done       <= done_d;
            err        <= err_d;
            code_addr  <= code_addr_d;
            vocab_addr <= vocab_addr_d;
            out_addr   <= out_addr_d;
        end
    end

    always_comb begin
        state_d      = state;
        target_d     = target;
        tok_cnt_d    = tok_cnt;
        prev_zero_d  = prev_zero;
        done_d       = done;
        err_d        = err;
        code_addr_d  = code_addr;
        vocab_addr_d = vocab_addr;
        out_addr_d   = out_addr;
        out_we       = 1'b0;
        out_wdata    = vocab_rdata;

        unique case (state)
            IDLE, DONE, ERR: begin
                if (cs) begin
                    done_d      = 1'b0;
                    err_d       = 1'b0;
                    code_addr_d = '0;
                    out_addr_d  = '0;
                    state_d     = RD_CODE;
                end
            end
            RD_CODE: state_d = EV_CODE;
            EV_CODE: begin
                if (code_rdata == END_CODE) begin
                    out_we    = 1'b1;
                    out_wdata = '0;
                    done_d    = 1'b1;
                    state_d   = DONE;
                end else if (&code_addr) begin
                    // no END_CODE before the code memory wraps
                    err_d   = 1'b1;
                    state_d = ERR;
                end else begin
                    target_d     = code_rdata;
                    tok_cnt_d    = '0;
                    vocab_addr_d = '0;
                    prev_zero_d  = 1'b1;
                    state_d      = RD_VOC;
                end
            end
            RD_VOC: state_d = EV_VOC;
            EV_VOC: begin
                if (b_zero) begin
                    if (prev_zero) begin
                        err_d   = 1'b1;
                        state_d = ERR;
                    end else if (hit) begin
                        code_addr_d = code_addr + 1'b1;
                        state_d     = RD_CODE;
                    end else begin
                        tok_cnt_d    = tok_cnt + 1'b1;
                        prev_zero_d  = 1'b1;
                        vocab_addr_d = vocab_addr + 1'b1;
                        state_d      = RD_VOC;
                    end
                end else if (hit) begin
                    // last output slot is kept for the terminator
                    if (&out_addr) begin
                        err_d   = 1'b1;
                        state_d = ERR;
                    end else begin
                        out_we       = 1'b1;
                        out_addr_d   = out_addr + 1'b1;
                        prev_zero_d  = 1'b0;
                        vocab_addr_d = vocab_addr + 1'b1;
                        state_d      = RD_VOC;
                    end
                end else if (&vocab_addr) begin
                    err_d   = 1'b1;
                    state_d = ERR;
                end else begin
                    prev_zero_d  = 1'b0;
                    vocab_addr_d = vocab_addr + 1'b1;
                    state_d      = RD_VOC;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_token_decoder.sv
// Bench for token_decoder: SRAM models, vector table,
// write scoreboard and reset / restart sequences.
module tb_token_decoder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cs = 1'b0;
    logic       busy, done, err, out_we;
    logic [3:0] code_addr, vocab_addr, out_addr;
    logic [7:0] code_rdata, vocab_rdata, out_wdata;

    token_decoder dut (
        .clk(clk), .rst_n(rst_n), .cs(cs),
        .busy(busy), .done(done), .err(err),
        .code_addr(code_addr), .code_rdata(code_rdata),
        .vocab_addr(vocab_addr), .vocab_rdata(vocab_rdata),
        .out_addr(out_addr), .out_wdata(out_wdata),
        .out_we(out_we)
    );

    always #5 clk = ~clk;

    logic [7:0] code_mem [16];
    logic [7:0] vocab_mem [16];
    logic [7:0] out_mem [16];

    always @(posedge clk) begin
        code_rdata  <= code_mem[code_addr];
        vocab_rdata <= vocab_mem[vocab_addr];
        if (out_we) out_mem[out_addr] <= out_wdata;
    end

    typedef struct packed {
        logic [15:0][7:0] voc;
        logic [15:0][7:0] cod;
        logic [15:0][7:0] str;
        int               len;
        logic             err;
        int               cycles;
    } vec_t;

    vec_t tbl [7];
    logic [11:0] sb [$];
    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // '.' stands for a 0 byte; in code strings 'F' is END_CODE
    function automatic logic [15:0][7:0] mk(input string s,
                                            input bit code);
        logic [15:0][7:0] r;
        logic [7:0] c;
        r = code ? {16{8'hFF}} : '0;
        for (int i = 0; i < s.len() && i < 16; i++) begin
            c = s[i];
            if (code)
                r[i] = (c == 8'h46) ? 8'hFF : c - 8'h30;
            else
                r[i] = (c == 8'h2E) ? 8'h00 : c;
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst_n && out_we) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL write_unexpected: got %0h@%0h expected none",
                         out_wdata, out_addr);
            end else if ({out_addr, out_wdata} !== sb[0]) begin
                errors++;
                $display("FAIL write: got %0h@%0h expected %0h@%0h",
                         out_wdata, out_addr, sb[0][7:0], sb[0][11:8]);
                void'(sb.pop_front());
            end else begin
                void'(sb.pop_front());
            end
        end
    end

    task automatic load(input vec_t v);
        sb.delete();
        for (int i = 0; i < 16; i++) begin
            code_mem[i]  = v.cod[i];
            vocab_mem[i] = v.voc[i];
            out_mem[i]   = 8'hEE;
        end
        for (int i = 0; i < v.len; i++)
            sb.push_back({4'(i), v.str[i]});
    endtask

    task automatic start();
        @(negedge clk);
        cs = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input vec_t v, input int hold, input string tag);
        int n;
        int stray;
        bit fin;
        fin = 1'b0;
        load(v);
        start();
        chk({tag, "_busy"}, 32'(busy), 1);
        chk({tag, "_done_clr"}, 32'(done), 0);
        chk({tag, "_err_clr"}, 32'(err), 0);
        for (n = 1; n <= 400; n++) begin
            if (n > hold) cs = 1'b0;
            @(posedge clk);
            #1;
            if (done || err) begin
                fin = 1'b1;
                break;
            end
        end
        cs = 1'b0;
        chk({tag, "_finished"}, 32'(fin), 1);
        chk({tag, "_cycles"}, 32'(n), 32'(v.cycles));
        chk({tag, "_done"}, 32'(done), 32'(!v.err));
        chk({tag, "_err"}, 32'(err), 32'(v.err));
        chk({tag, "_busy_end"}, 32'(busy), 0);
        chk({tag, "_sb_left"}, 32'(sb.size()), 0);
        stray = 0;
        for (int i = v.len; i < 16; i++)
            if (out_mem[i] !== 8'hEE) stray++;
        chk({tag, "_stray"}, 32'(stray), 0);
    endtask

    initial begin
        tbl[0] = '{mk("ab.c..", 0), mk("10F", 1), mk("cab.", 0),
                   4, 1'b0, 22};
        tbl[1] = '{mk("ab.c..", 0), mk("F", 1), mk(".", 0),
                   1, 1'b0, 2};
        tbl[2] = '{mk("ab.c..", 0), mk("2F", 1), mk("", 0),
                   0, 1'b1, 14};
        tbl[3] = '{mk("a.a.a.a.a.a.a.a.", 0),
                   mk("0000000000000000", 1),
                   mk("aaaaaaaaaaaaaaa", 0), 15, 1'b1, 92};
        tbl[4] = '{mk("", 0), mk("0F", 1), mk("", 0),
                   0, 1'b1, 4};
        tbl[5] = '{mk("xxxxxxxxxxxxxxxx", 0), mk("1", 1), mk("", 0),
                   0, 1'b1, 34};
        tbl[6] = '{mk("hi.yo..", 0), mk("110F", 1), mk("yoyohi.", 0),
                   7, 1'b1 ^ 1'b1, 38};

        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_we", 32'(out_we), 0);
        chk("rst_addrs", 32'({code_addr, vocab_addr, out_addr}), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++)
            run(tbl[i], 0, $sformatf("vec%0d", i));

        load(tbl[0]);
        start();
        cs = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("mid_busy", 32'(busy), 1);
        chk("mid_out_addr", 32'(out_addr), 1);
        chk("mid_vocab_addr", 32'(vocab_addr), 4);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_flags", 32'({done, err, out_we}), 0);
        chk("abort_addrs", 32'({code_addr, vocab_addr, out_addr}), 0);
        sb.delete();
        @(negedge clk);
        chk("abort_we_hold", 32'(out_we), 0);
        rst_n = 1'b1;

        run(tbl[0], 0, "rerun");
        run(tbl[0], 10, "cs_held");
        run(tbl[0], 0, "restart");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
